// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for a shared external ripple-carry adder.
// Optional ADDER_ARB_SUB_EN adds per-requester req_sub to compute A - B.
module adder_arbiter #(
   parameter int W      = 4,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [2*W-1:0]   req_a,
   input  logic [2*W-1:0]   req_b,
   input  logic [1:0]       req_ci,
`ifdef ADDER_ARB_SUB_EN
   input  logic [1:0]       req_sub,
`endif
   output logic [W-1:0]     add_a,
   output logic [W-1:0]     add_b,
   output logic             add_ci,
   input  logic [W-1:0]     add_s,
   input  logic             add_co,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [W-1:0]     rsp_s,
   output logic             rsp_co
);

   // state    | meaning
   // S_IDLE   | grant window, req_ready driven from req_valid and rr_ptr
   // S_SETTLE | operands held on the adder, down-counter running to zero
   // S_RESP   | result held until rsp_ready
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

   state_t         state;
   logic           rr_ptr;
   logic [3:0]     cnt;
   logic           owner;
   logic           gnt;
   logic           xfer;
   logic [W-1:0]   sel_a;
   logic [W-1:0]   sel_b;
   logic           sel_ci;
   logic [W-1:0]   nxt_b;
   logic           nxt_ci;

   always_comb begin
      req_ready = 2'b00;
      if (state == S_IDLE) begin
         case (req_valid)
            2'b01:   req_ready = 2'b01;
            2'b10:   req_ready = 2'b10;
            2'b11:   req_ready = rr_ptr ? 2'b10 : 2'b01;
            default: req_ready = 2'b00;
         endcase
      end
   end

   assign gnt    = req_ready[1];
   assign xfer   = |req_ready;
   assign sel_a  = gnt ? req_a[2*W-1:W] : req_a[W-1:0];
   assign sel_b  = gnt ? req_b[2*W-1:W] : req_b[W-1:0];
   assign sel_ci = gnt ? req_ci[1] : req_ci[0];

`ifdef ADDER_ARB_SUB_EN
   logic sel_sub;
   assign sel_sub = gnt ? req_sub[1] : req_sub[0];
   // A - B as A + ~B + 1; the requester's carry-in is irrelevant here
   assign nxt_b   = sel_sub ? ~sel_b : sel_b;
   assign nxt_ci  = sel_sub ? 1'b1 : sel_ci;
`else
   assign nxt_b   = sel_b;
   assign nxt_ci  = sel_ci;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rr_ptr    <= 1'b0;
         cnt       <= 4'd0;
         owner     <= 1'b0;
         add_a     <= '0;
         add_b     <= '0;
         add_ci    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_s     <= '0;
         rsp_co    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (xfer) begin
                  add_a  <= sel_a;
                  add_b  <= nxt_b;
                  add_ci <= nxt_ci;
                  owner  <= gnt;
                  rr_ptr <= ~gnt;
                  cnt    <= CNT_LOAD;
                  state  <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt == 4'd0) begin
                  rsp_s     <= add_s;
                  rsp_co    <= add_co;
                  rsp_id    <= owner;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized bench for adder_arbiter against a transaction-level model, plus directed pins.
module tb_adder_arbiter;
   localparam int W  = 4;
   localparam int ST = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [1:0]     req_valid = 2'b00;
   logic [1:0]     req_ready;
   logic [2*W-1:0] req_a = '0;
   logic [2*W-1:0] req_b = '0;
   logic [1:0]     req_ci = 2'b00;
`ifdef ADDER_ARB_SUB_EN
   logic [1:0]     req_sub = 2'b00;
`endif
   logic [W-1:0]   add_a, add_b, add_s;
   logic           add_ci, add_co;
   logic           rsp_valid;
   logic           rsp_ready = 1'b1;
   logic           rsp_id;
   logic [W-1:0]   rsp_s;
   logic           rsp_co;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // the shared adder the arbiter drives
   assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};

   adder_arbiter #(.W(W), .SETTLE(ST)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
`ifdef ADDER_ARB_SUB_EN
      .req_sub(req_sub),
`endif
      .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
      .add_s(add_s), .add_co(add_co),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_s(rsp_s), .rsp_co(rsp_co)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // transaction-level model: an operation occupies the adder for ST cycles, then a
   // response waits for the consumer; a new grant is only possible while not busy
   bit           m_idle = 1'b1;
   int           m_left = 0;
   bit           m_resp = 1'b0;
   bit           m_rr = 1'b0;
   logic [W-1:0] m_a = '0, m_b = '0;
   logic         m_ci = 1'b0;
   int           m_pend_sum = 0;
   bit           m_pend_id = 1'b0;
   logic [W-1:0] m_rs = '0;
   logic         m_rco = 1'b0;
   bit           m_rid = 1'b0;

   function automatic logic [1:0] exp_grant();
      if (!m_idle) return 2'b00;
      if (req_valid == 2'b11) return m_rr ? 2'b10 : 2'b01;
      return req_valid;
   endfunction

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         m_idle = 1'b1; m_left = 0; m_resp = 1'b0; m_rr = 1'b0;
         m_a = '0; m_b = '0; m_ci = 1'b0;
         m_rs = '0; m_rco = 1'b0; m_rid = 1'b0;
      end else if (m_idle) begin
         logic [1:0] g;
         g = exp_grant();
         if (g != 2'b00) begin
            int idx, a, b, ci;
            bit sub;
            idx = g[1] ? 1 : 0;
            a   = int'(req_a[idx*W +: W]);
            b   = int'(req_b[idx*W +: W]);
            ci  = req_ci[idx] ? 1 : 0;
            sub = 1'b0;
`ifdef ADDER_ARB_SUB_EN
            sub = req_sub[idx];
`endif
            m_a = req_a[idx*W +: W];
            if (sub) begin
               m_b = ~req_b[idx*W +: W];
               m_ci = 1'b1;
               m_pend_sum = a - b + (1 << W);
            end else begin
               m_b = req_b[idx*W +: W];
               m_ci = req_ci[idx];
               m_pend_sum = a + b + ci;
            end
            m_pend_id = g[1];
            m_rr = !g[1];
            m_idle = 1'b0;
            m_left = ST;
         end
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_resp = 1'b1;
            m_rs = W'(m_pend_sum);
            m_rco = m_pend_sum[W];
            m_rid = m_pend_id;
         end
      end else if (rsp_ready) begin
         m_resp = 1'b0;
         m_idle = 1'b1;
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         chk("rst_ready", 32'(req_ready), 32'd0);
         chk("rst_add_a", 32'(add_a), 32'd0);
         chk("rst_add_b", 32'(add_b), 32'd0);
         chk("rst_add_ci", 32'(add_ci), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_rsp_id", 32'(rsp_id), 32'd0);
         chk("rst_rsp_s", 32'(rsp_s), 32'd0);
         chk("rst_rsp_co", 32'(rsp_co), 32'd0);
      end else begin
         chk("req_ready", 32'(req_ready), 32'(exp_grant()));
         chk("add_a", 32'(add_a), 32'(m_a));
         chk("add_b", 32'(add_b), 32'(m_b));
         chk("add_ci", 32'(add_ci), 32'(m_ci));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
         chk("rsp_id", 32'(rsp_id), 32'(m_rid));
         chk("rsp_s", 32'(rsp_s), 32'(m_rs));
         chk("rsp_co", 32'(rsp_co), 32'(m_rco));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_rsp(input string nm);
      int n;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 30) begin
         step();
         sample();
         n++;
      end
      if (n >= 30) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout got no rsp_valid required rsp_valid=1 within 30 cycles", nm);
      end
   endtask

   initial begin
      bit gq[$];
      bit iq[$];

      // reset state
      repeat (2) step();
      sample();
      chk("t_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t_rst_add_a", 32'(add_a), 32'd0);
      step();
      rst_n = 1'b1;

      // single add from requester 0: 3 + 4
      step();
      req_a = {4'h0, 4'h3}; req_b = {4'h0, 4'h4}; req_ci = 2'b00; req_valid = 2'b01;
      sample();
      chk("t030_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 2'b00;
      sample();
      chk("t030_early1", 32'(rsp_valid), 32'd0);
      step();
      sample();
      chk("t030_early2", 32'(rsp_valid), 32'd0);
      step();
      sample();
      chk("t030_valid", 32'(rsp_valid), 32'd1);
      chk("t030_s", 32'(rsp_s), 32'd7);
      chk("t030_co", 32'(rsp_co), 32'd0);
      chk("t030_id", 32'(rsp_id), 32'd0);
      step();

      // carry wrap from requester 1: F + 1 + 1
      step();
      req_a = {4'hF, 4'h0}; req_b = {4'h1, 4'h0}; req_ci = 2'b10; req_valid = 2'b10;
      sample();
      chk("t032_ready", 32'(req_ready), 32'd2);
      step();
      req_valid = 2'b00;
      wait_rsp("t032");
      chk("t032_s", 32'(rsp_s), 32'd1);
      chk("t032_co", 32'(rsp_co), 32'd1);
      chk("t032_id", 32'(rsp_id), 32'd1);
      step();

      // back-pressure: result must hold, no grants while the requester keeps asking
      step();
      req_a = {4'h0, 4'h9}; req_b = {4'h0, 4'h2}; req_ci = 2'b00; req_valid = 2'b01;
      rsp_ready = 1'b0;
      sample();
      chk("t033_ready", 32'(req_ready), 32'd1);
      step();
      wait_rsp("t033");
      chk("t033_s", 32'(rsp_s), 32'd11);
      for (int i = 0; i < 5; i++) begin
         step();
         sample();
         chk("t033_hold_valid", 32'(rsp_valid), 32'd1);
         chk("t033_hold_s", 32'(rsp_s), 32'd11);
         chk("t033_hold_ready", 32'(req_ready), 32'd0);
      end
      step();
      rsp_ready = 1'b1; req_valid = 2'b00;
      step();

      // both requesters continuously: grants alternate, starting at 1 (last grant was 0)
      step();
      req_a = {4'h5, 4'hA}; req_b = {4'h6, 4'h3}; req_ci = 2'b01; req_valid = 2'b11;
      for (int i = 0; i < 40; i++) begin
         sample();
         if (req_ready != 2'b00) gq.push_back(req_ready[1]);
         if (rsp_valid) iq.push_back(rsp_id);
         step();
      end
      req_valid = 2'b00;
      checks++;
      if (gq.size() < 8) begin
         errors++;
         $display("FAIL t031_count got %0d grants required at least 8", gq.size());
      end
      if (gq.size() > 0) chk("t031_first", 32'(gq[0]), 32'd1);
      for (int i = 1; i < gq.size(); i++) chk("t031_alt_grant", 32'(gq[i]), 32'(!gq[i-1]));
      for (int i = 1; i < iq.size(); i++) chk("t031_alt_id", 32'(iq[i]), 32'(!iq[i-1]));
      repeat (6) step();

      // reset in the middle of SETTLE
      req_a = {4'h0, 4'h6}; req_b = {4'h0, 4'h5}; req_ci = 2'b01; req_valid = 2'b01;
      sample();
      chk("t034_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 2'b00;
      sample();
      chk("t034_pre_add_a", 32'(add_a), 32'd6);
      step();
      rst_n = 1'b0;
      #1;
      chk("t034_add_a", 32'(add_a), 32'd0);
      chk("t034_add_b", 32'(add_b), 32'd0);
      chk("t034_add_ci", 32'(add_ci), 32'd0);
      chk("t034_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t034_rsp_s", 32'(rsp_s), 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sample();
         chk("t034_no_rsp", 32'(rsp_valid), 32'd0);
         step();
      end
      req_valid = 2'b11;
      sample();
      chk("t034_grant0", 32'(req_ready), 32'd1);
      step();
      req_valid = 2'b00;
      wait_rsp("t034");
      step();

`ifdef ADDER_ARB_SUB_EN
      // subtraction 5 - 3 from requester 0
      step();
      req_a = {4'h0, 4'h5}; req_b = {4'h0, 4'h3}; req_ci = 2'b00; req_sub = 2'b01;
      req_valid = 2'b01;
      sample();
      chk("t035_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 2'b00; req_sub = 2'b00;
      wait_rsp("t035");
      chk("t035_s", 32'(rsp_s), 32'd2);
      chk("t035_co", 32'(rsp_co), 32'd1);
      step();
`endif

      // randomized traffic with occasional mid-flight resets
      for (int i = 0; i < 3000; i++) begin
         step();
         if ($urandom_range(0, 399) == 0) begin
            req_valid = 2'b00;
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
         end else begin
            if ($urandom_range(0, 1) == 0) req_valid = 2'($urandom);
            req_a = 8'($urandom);
            req_b = 8'($urandom);
            req_ci = 2'($urandom);
`ifdef ADDER_ARB_SUB_EN
            req_sub = 2'($urandom);
`endif
            rsp_ready = ($urandom_range(0, 9) < 7);
         end
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      repeat (8) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
